// File: rtl/axis_deltasigma_decimator.sv
// ============================================================================
// axis_deltasigma_decimator : AXI-Stream CIC (sinc^N) decimating filter
// rev 1.0
// ============================================================================
`default_nettype none

module axis_deltasigma_decimator #(
  parameter int S_AXIS_TDATA_WIDTH = 8,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int DECIMATION         = 64,
  parameter int ORDER              = 3
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          overrun
);

  localparam int LOG2R = $clog2(DECIMATION);
  localparam int W     = S_AXIS_TDATA_WIDTH + ORDER * LOG2R;
  localparam logic [LOG2R-1:0] LAST_PHASE = LOG2R'(DECIMATION - 1);

  logic [W-1:0]                  integ      [ORDER];
  logic [W-1:0]                  integ_next [ORDER];
  logic [W-1:0]                  dly        [ORDER];
  logic [W-1:0]                  comb_in    [ORDER];
  logic [W-1:0]                  carry;
  logic [W-1:0]                  comb_last;
  logic [W-1:0]                  x_ext;
  logic [LOG2R-1:0]              phase;
  logic [M_AXIS_TDATA_WIDTH-1:0] out_word;
  logic                          last_beat;
  logic                          stall;
  logic                          accept;
  logic                          decim;

  assign x_ext = {{(W - S_AXIS_TDATA_WIDTH){s_axis_tdata[S_AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};

  // Only the beat that completes a frame can be held off by an unaccepted result.
  assign last_beat     = (phase == LAST_PHASE);
  assign stall         = last_beat & m_axis_tvalid & ~m_axis_tready;
  assign s_axis_tready = aresetn & enable & ~stall;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign decim         = accept & last_beat;

  always_comb begin
    carry = x_ext;
    for (int k = 0; k < ORDER; k++) begin
      integ_next[k] = integ[k] + carry;
      carry         = integ_next[k];
    end
    for (int k = 0; k < ORDER; k++) begin
      comb_in[k] = carry;
      carry      = carry - dly[k];
    end
    comb_last = carry;
  end

  generate
    if (M_AXIS_TDATA_WIDTH > W) begin : g_out_sext
      assign out_word = {{(M_AXIS_TDATA_WIDTH - W){comb_last[W-1]}}, comb_last};
    end else if (M_AXIS_TDATA_WIDTH == W) begin : g_out_same
      assign out_word = comb_last;
    end else begin : g_out_trunc
      assign out_word = comb_last[W-1 -: M_AXIS_TDATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int k = 0; k < ORDER; k++) begin
        integ[k] <= '0;
        dly[k]   <= '0;
      end
      phase         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (!enable) begin
        for (int k = 0; k < ORDER; k++) begin
          integ[k] <= '0;
          dly[k]   <= '0;
        end
        phase   <= '0;
        overrun <= 1'b0;
      end else begin
        if (accept) begin
          for (int k = 0; k < ORDER; k++) begin
            integ[k] <= integ_next[k];
          end
          phase <= phase + 1'b1;
        end
        if (decim) begin
          for (int k = 0; k < ORDER; k++) begin
            dly[k] <= comb_in[k];
          end
        end
        if (s_axis_tvalid & stall) begin
          overrun <= 1'b1;
        end
      end
      // A pending word survives enable going low; only acceptance retires it.
      if (decim) begin
        m_axis_tdata  <= out_word;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_deltasigma_decimator.sv
// Testbench for axis_deltasigma_decimator: three filter configurations checked
// against an impulse-response (convolution) reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_axis_deltasigma_decimator;

  localparam int ORD [3] = '{1, 3, 5};
  localparam int RAT [3] = '{4, 4, 4096};
  localparam int WID [3] = '{10, 14, 68};
  localparam int HMAX = 20480;
  localparam int HIST = 32768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            aresetn;
  logic [7:0]      tdata;
  logic [2:0]      en, valid, mready;
  wire  [2:0]      sready, mvalid, ovr;
  wire  [2:0][31:0] mdata;

  int          checks = 0;
  int          errors = 0;
  longint      h    [3][HMAX];
  longint      tmp  [HMAX];
  int          hlen [3];
  int          hist [3][HIST];
  int          cnt  [3];
  int          t2_exp [5] = '{20, 60, 64, 64, 64};

  axis_deltasigma_decimator #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(32),
                              .DECIMATION(4), .ORDER(1)) dut0 (
    .aclk(clk), .aresetn(aresetn), .enable(en[0]), .s_axis_tdata(tdata),
    .s_axis_tvalid(valid[0]), .s_axis_tready(sready[0]), .m_axis_tdata(mdata[0]),
    .m_axis_tvalid(mvalid[0]), .m_axis_tready(mready[0]), .overrun(ovr[0]));

  axis_deltasigma_decimator #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(32),
                              .DECIMATION(4), .ORDER(3)) dut1 (
    .aclk(clk), .aresetn(aresetn), .enable(en[1]), .s_axis_tdata(tdata),
    .s_axis_tvalid(valid[1]), .s_axis_tready(sready[1]), .m_axis_tdata(mdata[1]),
    .m_axis_tvalid(mvalid[1]), .m_axis_tready(mready[1]), .overrun(ovr[1]));

  axis_deltasigma_decimator #(.S_AXIS_TDATA_WIDTH(8), .M_AXIS_TDATA_WIDTH(32),
                              .DECIMATION(4096), .ORDER(5)) dut2 (
    .aclk(clk), .aresetn(aresetn), .enable(en[2]), .s_axis_tdata(tdata),
    .s_axis_tvalid(valid[2]), .s_axis_tready(sready[2]), .m_axis_tdata(mdata[2]),
    .m_axis_tvalid(mvalid[2]), .m_axis_tready(mready[2]), .overrun(ovr[2]));

  // Impulse response of sinc^N: N-fold convolution of a length-R box.
  task automatic build_h(input int i);
    longint s;
    int     nl;
    hlen[i] = 1;
    h[i][0] = 1;
    repeat (ORD[i]) begin
      s  = 0;
      nl = hlen[i] + RAT[i] - 1;
      for (int n = 0; n < nl; n++) begin
        if (n < hlen[i]) s += h[i][n];
        if (n >= RAT[i] && n - RAT[i] < hlen[i]) s -= h[i][n - RAT[i]];
        tmp[n] = s;
      end
      for (int n = 0; n < nl; n++) h[i][n] = tmp[n];
      hlen[i] = nl;
    end
  endtask

  // Filter output at the current sample count, wrapped to W bits, then scaled to 32.
  function automatic logic [31:0] model(input int i);
    logic signed [127:0] acc, hh, xx, r;
    int n, len;
    acc = 0;
    n   = cnt[i];
    len = (n < hlen[i]) ? n : hlen[i];
    for (int j = 0; j < len; j++) begin
      hh  = h[i][j];
      xx  = hist[i][n - 1 - j];
      acc = acc + hh * xx;
    end
    if (WID[i] <= 32) r = (acc <<< (128 - WID[i])) >>> (128 - WID[i]);
    else              r = acc >>> (WID[i] - 32);
    return r[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int i, input logic [7:0] d);
    int t;
    tdata    = d;
    valid[i] = 1'b1;
    #1;
    t = 0;
    while (!sready[i] && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!sready[i]) begin
      chk("sready_timeout", 32'(sready[i]), 32'd1);
      valid[i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    valid[i]          = 1'b0;
    hist[i][cnt[i]]   = $signed(d);
    cnt[i]++;
    if (cnt[i] % RAT[i] == 0) begin
      chk("out_valid", 32'(mvalid[i]), 32'd1);
      chk("out_data", mdata[i], model(i));
    end else if (mready[i]) begin
      chk("idle_valid", 32'(mvalid[i]), 32'd0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aresetn = 1'b0;
    en      = 3'b111;
    valid   = 3'b000;
    mready  = 3'b111;
    tdata   = 8'h00;
    for (int i = 0; i < 3; i++) begin
      build_h(i);
      cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tvalid", 32'(mvalid[i]), 32'd0);
      chk("rst_tdata", mdata[i], 32'd0);
      chk("rst_overrun", 32'(ovr[i]), 32'd0);
      chk("rst_tready", 32'(sready[i]), 32'd0);
    end
    aresetn = 1'b1;

    // ORDER=1 constant +1
    repeat (12) beat(0, 8'h01);
    chk("t1_data", mdata[0], 32'd4);

    // alternating then all -1
    for (int k = 0; k < 8; k++) beat(0, (k % 2 == 1) ? 8'hFF : 8'h01);
    chk("t3_zero", mdata[0], 32'd0);
    repeat (8) beat(0, 8'hFF);
    chk("t3_neg", mdata[0], 32'hFFFF_FFFC);

    // back-pressure on the completing beat
    repeat (4) beat(0, 8'h01);
    mready[0] = 1'b0;
    repeat (3) beat(0, 8'h01);
    tdata    = 8'h01;
    valid[0] = 1'b1;
    #1;
    chk("t4_stall", 32'(sready[0]), 32'd0);
    @(posedge clk); #1;
    chk("t4_overrun", 32'(ovr[0]), 32'd1);
    chk("t4_hold_valid", 32'(mvalid[0]), 32'd1);
    chk("t4_hold_data", mdata[0], 32'd4);
    mready[0] = 1'b1;
    #1;
    chk("t4_release", 32'(sready[0]), 32'd1);
    beat(0, 8'h01);
    chk("t4_data", mdata[0], 32'd4);
    chk("t4_overrun_sticky", 32'(ovr[0]), 32'd1);

    // enable low: state and overrun cleared, pending word kept
    mready[0] = 1'b0;
    en[0]     = 1'b0;
    @(posedge clk); #1;
    chk("en_overrun", 32'(ovr[0]), 32'd0);
    chk("en_tready", 32'(sready[0]), 32'd0);
    chk("en_keep_valid", 32'(mvalid[0]), 32'd1);
    chk("en_keep_data", mdata[0], 32'd4);
    mready[0] = 1'b1;
    @(posedge clk); #1;
    chk("en_drain", 32'(mvalid[0]), 32'd0);
    en[0]  = 1'b1;
    cnt[0] = 0;

    // asynchronous reset mid-frame
    repeat (2) beat(0, 8'h01);
    #1;
    aresetn = 1'b0;
    #1;
    chk("t5_valid", 32'(mvalid[0]), 32'd0);
    chk("t5_data", mdata[0], 32'd0);
    chk("t5_tready", 32'(sready[0]), 32'd0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    repeat (4) beat(0, 8'h01);
    chk("t5_first", mdata[0], 32'd4);

    // ORDER=3 step response
    for (int k = 0; k < 20; k++) begin
      beat(1, 8'h01);
      if (cnt[1] % 4 == 0) chk("t2_step", mdata[1], 32'(t2_exp[cnt[1] / 4 - 1]));
    end

    // random samples with idle gaps
    for (int k = 0; k < 64; k++) begin
      beat(1, 8'($urandom));
      if ($urandom_range(3) == 0) begin
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < 48; k++) begin
      beat(0, 8'($urandom));
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
    end

    // ORDER=5, R=4096, truncated output
    repeat (7 * 4096) beat(2, 8'd127);
    chk("t6_steady", mdata[2], 32'h7F00_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
